// File: rtl/seg_scan_mux.sv
// seg_scan_mux: N-digit 7-segment scanner with frame-coherent double buffering,
// per-digit blink, PWM brightness and a blank lead-in on every digit slot.
module seg_scan_mux #(
    parameter int NUM_DIGITS     = 8,
    parameter int SEG_W          = 7,
    parameter int DIV            = 1350,
    parameter int BLANK_TICKS    = 1,
    parameter int BRIGHT_W       = 3,
    parameter int BLINK_FRAMES   = 64,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit SEL_ACTIVE_LOW = 1'b0
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_enable,
    input  logic [NUM_DIGITS*SEG_W-1:0] i_digits_in,
    input  logic                        i_load,
    input  logic                        i_blink_en,
    input  logic [NUM_DIGITS-1:0]       i_blink_mask,
    input  logic [BRIGHT_W-1:0]         i_brightness,
    output logic [SEG_W-1:0]            o_segout,
    output logic [NUM_DIGITS-1:0]       o_selector,
    output logic                        o_frame_done
);
    localparam int SLOT_TICKS = BLANK_TICKS + 2**BRIGHT_W;
    localparam int CW = $clog2(DIV);
    localparam int PW = $clog2(SLOT_TICKS);
    localparam int DW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [SEG_W-1:0]      SEG_OFF = {SEG_W{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] SEL_OFF = {NUM_DIGITS{SEL_ACTIVE_LOW}};

    logic [CW-1:0]               r_cnt;
    logic [PW-1:0]               r_phase;
    logic [DW-1:0]               r_dig;
    logic [FW-1:0]               r_frame;
    logic                        r_blink;
    logic [NUM_DIGITS*SEG_W-1:0] r_pend;
    logic [NUM_DIGITS*SEG_W-1:0] r_act;
    logic                        r_pend_v;
    logic [SEG_W-1:0]            r_seg;
    logic [NUM_DIGITS-1:0]       r_sel;

    logic                  w_tick;
    logic                  w_slot_end;
    logic                  w_frame_end;
    logic                  w_frame_wrap;
    logic                  w_lit;
    logic [SEG_W-1:0]      w_seg;
    logic [NUM_DIGITS-1:0] w_onehot;

    assign w_tick       = i_enable && r_cnt == CW'(DIV - 1);
    assign w_slot_end   = w_tick && r_phase == PW'(SLOT_TICKS - 1);
    assign w_frame_end  = w_slot_end && r_dig == DW'(NUM_DIGITS - 1);
    assign w_frame_wrap = r_frame == FW'(BLINK_FRAMES - 1);
    // Lit only after the blank lead-in, for brightness+1 ticks, unless blinked off.
    assign w_lit = i_enable && int'(r_phase) >= BLANK_TICKS
                 && int'(r_phase) - BLANK_TICKS <= int'(i_brightness)
                 && !(i_blink_en && i_blink_mask[r_dig] && r_blink);
    assign w_seg    = r_act[r_dig*SEG_W +: SEG_W];
    assign w_onehot = NUM_DIGITS'(1) << r_dig;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt    <= '0;
            r_phase  <= '0;
            r_dig    <= '0;
            r_frame  <= '0;
            r_blink  <= 1'b0;
            r_pend   <= '0;
            r_act    <= '0;
            r_pend_v <= 1'b0;
            r_seg    <= SEG_OFF;
            r_sel    <= SEL_OFF;
        end else begin
            r_cnt <= (!i_enable || w_tick) ? '0 : r_cnt + CW'(1);
            if (!i_enable) begin
                r_phase <= '0;
                r_dig   <= '0;
                r_frame <= '0;
            end else if (w_tick) begin
                r_phase <= w_slot_end ? '0 : r_phase + PW'(1);
                if (w_slot_end)
                    r_dig <= w_frame_end ? '0 : r_dig + DW'(1);
                if (w_frame_end) begin
                    r_frame <= w_frame_wrap ? '0 : r_frame + FW'(1);
                    r_blink <= r_blink ^ w_frame_wrap;
                end
            end
            if (i_load)
                r_pend <= i_digits_in;
            // A load on the boundary cycle bypasses the pending buffer entirely.
            r_pend_v <= (i_load || r_pend_v) && !w_frame_end;
            if (w_frame_end && (i_load || r_pend_v))
                r_act <= i_load ? i_digits_in : r_pend;
            r_sel <= w_lit ? w_onehot ^ SEL_OFF : SEL_OFF;
            r_seg <= w_lit ? w_seg ^ SEG_OFF : SEG_OFF;
        end
    end

    assign o_segout     = r_seg;
    assign o_selector   = r_sel;
    assign o_frame_done = w_frame_end;
endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: directed checks of scanning, buffering, blink, brightness,
// enable and reset behaviour for a 4-digit, DIV=4 configuration.
module tb_seg_scan_mux;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [27:0] digits_in = '0;
    logic        load = 1'b0;
    logic        blink_en = 1'b0;
    logic [3:0]  blink_mask = '0;
    logic [1:0]  brightness = 2'd3;
    logic [6:0]  segout;
    logic [3:0]  selector;
    logic        frame_done;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    int n_multi = 0;

    seg_scan_mux #(
        .NUM_DIGITS(4), .SEG_W(7), .DIV(4), .BLANK_TICKS(1), .BRIGHT_W(2),
        .BLINK_FRAMES(2), .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b0)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_digits_in(digits_in),
        .i_load(load), .i_blink_en(blink_en), .i_blink_mask(blink_mask),
        .i_brightness(brightness), .o_segout(segout), .o_selector(selector),
        .o_frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (rst_n && $countones(selector) > 1)
            n_multi++;

    task automatic goto(input int n);
        while (cyc < n) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic restart();
        rst_n = 1'b0;
        load  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic pulse_load(input logic [27:0] d);
        digits_in = d;
        load = 1'b1;
        goto(cyc + 1);
        load = 1'b0;
    endtask

    task automatic count_lit(input int first, input int last, output int n);
        n = 0;
        for (int k = first; k <= last; k++) begin
            goto(k);
            if (selector != 4'b0)
                n++;
        end
    endtask

    initial begin
        int n;
        enable = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_sel", 32'(selector), 32'h0);
        chk("reset_seg", 32'(segout), 32'h7F);
        chk("reset_fd", 32'(frame_done), 32'h0);
        rst_n = 1'b1;
        cyc = 0;
        pulse_load(28'h0FC06F3F);
        goto(10);  chk("f1_d0_sel", 32'(selector), 32'h1);
                   chk("f1_d0_seg_zero_buf", 32'(segout), 32'h7F);
        goto(78);  chk("fd_before", 32'(frame_done), 32'h0);
        goto(79);  chk("fd_at_79", 32'(frame_done), 32'h1);
        goto(80);  chk("fd_after", 32'(frame_done), 32'h0);
        goto(84);  chk("f2_blank_sel", 32'(selector), 32'h0);
                   chk("f2_blank_seg", 32'(segout), 32'h7F);
        goto(85);  chk("f2_d0_sel", 32'(selector), 32'h1);
                   chk("f2_d0_seg", 32'(segout), 32'h40);
        goto(100); chk("f2_d0_last", 32'(selector), 32'h1);
        goto(101); chk("f2_d1_blank", 32'(selector), 32'h0);
        goto(105); chk("f2_d1_sel", 32'(selector), 32'h2);
        goto(160); brightness = 2'd0;
        count_lit(161, 180, n);
        chk("bright0_on_clk", 32'(n), 32'd4);
        goto(240); brightness = 2'd3;
        count_lit(241, 260, n);
        chk("bright3_on_clk", 32'(n), 32'd16);

        restart();
        goto(10);  pulse_load(28'h000005B);
        goto(30);  pulse_load(28'h0000006);
        goto(50);  chk("ab_f1_zero", 32'(segout), 32'h7F);
                   chk("ab_f1_sel", 32'(selector), 32'h4);
        goto(90);  chk("ab_f2_b", 32'(segout), 32'h79);
        goto(170); chk("ab_f3_b", 32'(segout), 32'h79);

        restart();
        goto(40);  pulse_load(28'h0000011);
        goto(79);  pulse_load(28'h000004F);
        goto(90);  chk("c_f2", 32'(segout), 32'h30);
        goto(170); chk("c_f3_same", 32'(segout), 32'h30);

        restart();
        blink_en = 1'b1;
        blink_mask = 4'b0100;
        pulse_load(28'h0FC06F3F);
        goto(50);  chk("blk_f1_d2", 32'(selector), 32'h4);
        goto(130); chk("blk_f2_d2", 32'(selector), 32'h4);
                   chk("blk_f2_d2_seg", 32'(segout), 32'h7E);
        goto(190); chk("blk_f3_d1", 32'(selector), 32'h2);
        goto(210); chk("blk_f3_d2_dark", 32'(selector), 32'h0);
                   chk("blk_f3_d2_seg", 32'(segout), 32'h7F);
        goto(290); chk("blk_f4_d2_dark", 32'(selector), 32'h0);
        goto(370); chk("blk_f5_d2", 32'(selector), 32'h4);
                   chk("blk_f5_d2_seg", 32'(segout), 32'h7E);
        goto(410); enable = 1'b0;
        goto(411); chk("dis_sel", 32'(selector), 32'h0);
                   chk("dis_seg", 32'(segout), 32'h7F);
        goto(420); pulse_load(28'h000006D);
        goto(430); chk("dis_fd", 32'(frame_done), 32'h0);
        goto(440); enable = 1'b1;
        goto(444); chk("ren_blank", 32'(selector), 32'h0);
        goto(445); chk("ren_d0_sel", 32'(selector), 32'h1);
                   chk("ren_d0_old", 32'(segout), 32'h40);
        goto(518); chk("ren_fd_before", 32'(frame_done), 32'h0);
        goto(519); chk("ren_fd", 32'(frame_done), 32'h1);
        goto(530); chk("ren_pending_xfer", 32'(segout), 32'h12);
        goto(550); chk("pre_rst_d1", 32'(selector), 32'h2);
        rst_n = 1'b0;
        #1;
        chk("async_rst_sel", 32'(selector), 32'h0);
        chk("async_rst_seg", 32'(segout), 32'h7F);
        chk("async_rst_fd", 32'(frame_done), 32'h0);
        restart();
        goto(4);   chk("post_rst_blank", 32'(selector), 32'h0);
        goto(5);   chk("post_rst_d0", 32'(selector), 32'h1);
                   chk("post_rst_buf0", 32'(segout), 32'h7F);
        chk("never_two_sel", 32'(n_multi), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
